// File: rtl/arf_stream_responder_if.sv
// Bundle between a push-stream producer, the responder, and a pulling initiator.
// The slave modport is the responder's view; master is the view of whatever
// drives the stream and the pull request.
interface arf_stream_responder_if #(
  parameter int data_width = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [data_width-1:0] s_data;
  logic                  req;
  logic                  ack;
  logic [data_width-1:0] dout;

  modport slave (
    input  s_valid,
    input  s_data,
    input  req,
    output s_ready,
    output ack,
    output dout
  );

  modport master (
    output s_valid,
    output s_data,
    output req,
    input  s_ready,
    input  ack,
    input  dout
  );
endinterface

// File: rtl/arf_stream_responder.sv
// Responder end of the arf req/ack pull handshake, fed from a valid/ready
// push stream through a small FIFO. A pull is answered with a one-cycle ack
// and the oldest buffered word; ack is never asserted on two consecutive
// cycles, so an initiator that drops req one cycle after ack never gets a
// duplicate delivery.
module arf_stream_responder #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int ptr_width  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  arf_stream_responder_if.slave bus,
  output logic [31:0]          count,
  output logic [ptr_width:0]   level
);

  localparam logic [ptr_width-1:0] PTR_ONE    = ptr_width'(1);
  localparam logic [ptr_width:0]   LEVEL_ONE  = (ptr_width + 1)'(1);
  localparam logic [ptr_width:0]   LEVEL_ZERO = (ptr_width + 1)'(0);
  localparam logic [ptr_width:0]   LEVEL_FULL = (ptr_width + 1)'(depth);

  logic [data_width-1:0] mem_q [depth];

  logic [ptr_width-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ptr_width:0]    level_q, level_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;

  logic                  s_ready_s;
  logic                  push_s;
  logic                  pop_s;

  // Handshake decisions and next-state for pointers, occupancy and the response.
  always_comb begin
    s_ready_s = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ack_d     = 1'b0;
    dout_d    = dout_q;
    count_d   = count_q;

    // Ready depends only on registered occupancy: no same-cycle bypass.
    s_ready_s = (level_q != LEVEL_FULL);
    push_s    = bus.s_valid & s_ready_s;
    // Occupancy before this edge gates the pop, so a word pushed now is
    // never returned on the same edge.
    pop_s     = bus.req & ~ack_q & (level_q != LEVEL_ZERO);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      ack_d    = 1'b1;
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q + 32'd1;
    end else begin
      ack_d    = 1'b0;
      dout_d   = dout_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state; asynchronous reset drops every buffered word at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      count_q  <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
    end
  end

  // Word storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.ack     = ack_q;
  assign bus.dout    = dout_q;
  assign count       = count_q;
  assign level       = level_q;

endmodule

// File: tb/tb_arf_stream_responder.sv
// Scoreboard bench for arf_stream_responder: words accepted on the stream
// are queued as expected deliveries and compared when ack appears.
module tb_arf_stream_responder;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk;
  logic          rst;
  logic [31:0]   count;
  logic [PW:0]   level;

  arf_stream_responder_if #(.data_width(DW)) bus ();

  arf_stream_responder #(
    .data_width(DW),
    .depth     (DEPTH),
    .ptr_width (PW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .count(count),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb [$];
  logic          m_ack;
  logic [DW-1:0] m_dout;
  logic [31:0]   m_count;
  bit            last_push;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ack     = 1'b0;
    m_dout    = '0;
    m_count   = 32'd0;
    last_push = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ack"},     64'(bus.ack),     64'd0);
    check_eq({tag, "_dout"},    64'(bus.dout),    64'd0);
    check_eq({tag, "_count"},   64'(count),       64'd0);
    check_eq({tag, "_level"},   64'(level),       64'd0);
    check_eq({tag, "_s_ready"}, 64'(bus.s_ready), 64'd1);
  endtask

  // One clock edge: predict from the model, advance it, compare outputs.
  task automatic step();
    bit            do_push;
    bit            do_pop;
    logic [DW-1:0] w;
    do_pop  = bus.req && !m_ack && (sb.size() != 0);
    do_push = bus.s_valid && (sb.size() != DEPTH);
    w       = bus.s_data;
    @(posedge clk);
    #1;
    if (do_pop) begin
      m_dout = sb.pop_front();
      m_count++;
    end
    if (do_push) sb.push_back(w);
    m_ack     = do_pop;
    last_push = do_push;
    check_eq("ack",     64'(bus.ack),     64'(m_ack));
    check_eq("dout",    64'(bus.dout),    64'(m_dout));
    check_eq("level",   64'(level),       64'(sb.size()));
    check_eq("s_ready", 64'(bus.s_ready), 64'(sb.size() != DEPTH));
    check_eq("count",   64'(count),       64'(m_count));
  endtask

  initial begin
    model_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.req     = 1'b0;

    // Reset with random inputs, observed before any clock edge.
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'($urandom);
    bus.s_data  = $urandom;
    bus.req     = 1'($urandom);
    #2;
    check_reset_state("rst0");
    #4;
    bus.s_valid = 1'b0;
    bus.req     = 1'b1;
    rst         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_noack", 64'(bus.ack), 64'd0);
    end

    // Fill: 1..4 then hold 5 while full.
    bus.req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(i);
      step();
    end
    bus.s_data = 32'd5;
    step();
    step();
    check_eq("fill_level",   64'(level),       64'd4);
    check_eq("fill_s_ready", 64'(bus.s_ready), 64'd0);

    // Drain with req held: 5 goes in once a slot opens.
    bus.req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (m_count == 32'd5 && sb.size() == 0) break;
      step();
      if (last_push) bus.s_valid = 1'b0;
    end
    check_eq("drain_count", 64'(count),    64'd5);
    check_eq("drain_level", 64'(level),    64'd0);
    check_eq("drain_last",  64'(bus.dout), 64'd5);
    step();

    // Latency: push 7 into empty FIFO with req high.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd7;
    step();
    check_eq("lat_edge_n", 64'(bus.ack), 64'd0);
    bus.s_valid = 1'b0;
    step();
    check_eq("lat_ack",  64'(bus.ack),  64'd1);
    check_eq("lat_dout", 64'(bus.dout), 64'd7);
    step();

    // Concurrent pop and blocked push on a full FIFO.
    bus.req = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(i);
      step();
    end
    bus.s_data = 32'd14;
    bus.req    = 1'b1;
    step();
    check_eq("conc_ack",     64'(bus.ack),     64'd1);
    check_eq("conc_dout",    64'(bus.dout),    64'd10);
    check_eq("conc_level",   64'(level),       64'd3);
    check_eq("conc_s_ready", 64'(bus.s_ready), 64'd1);
    step();
    check_eq("conc_push14", 64'(level), 64'd4);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 2) break;
      step();
    end
    check_eq("pre_rst_level", 64'(level), 64'd2);

    // Mid-stream reset between edges with req pending.
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_ack",   64'(bus.ack), 64'd0);
    check_eq("mid_level", 64'(level),   64'd0);
    check_eq("mid_count", 64'(count),   64'd0);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mid_noack", 64'(bus.ack), 64'd0);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h55;
    step();
    bus.s_valid = 1'b0;
    step();
    check_eq("mid_new_ack",  64'(bus.ack),  64'd1);
    check_eq("mid_new_dout", 64'(bus.dout), 64'h55);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
